// File: rtl/axi_mem_ctrl.sv
// rtl/axi_mem_ctrl.sv - single-port memory controller serving one AXI write or read burst at a time from FIFO-buffered channels
module axi_mem_ctrl #(
    parameter int A   = 32,
    parameter int I   = 4,
    parameter int L   = 4,
    parameter int D   = 64,
    parameter int M   = D/8,
    parameter int MAW = 10
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    output logic                 awfifo_pop,
    input  logic [I+L+3+2+A-1:0] awfifo_do,
    input  logic                 awfifo_empty,
    output logic                 wdfifo_pop,
    input  logic [I+M+1+D-1:0]   wdfifo_do,
    input  logic                 wdfifo_empty,
    output logic                 bfifo_push,
    output logic [I+2-1:0]       bfifo_di,
    input  logic                 bfifo_full,
    output logic                 arfifo_pop,
    input  logic [I+L+3+2+A-1:0] arfifo_do,
    input  logic                 arfifo_empty,
    output logic                 rdfifo_push,
    output logic [I+1+2+D-1:0]   rdfifo_di,
    input  logic                 rdfifo_full,
    output logic                 mem_en,
    output logic [M-1:0]         mem_we,
    output logic [MAW-1:0]       mem_addr,
    output logic [D-1:0]         mem_wdata,
    input  logic [D-1:0]         mem_rdata,
    output logic                 busy
);
    localparam int AXW = I + L + 3 + 2 + A;

    typedef enum logic [2:0] {IDLE, WR, WRESP, RD_ADDR, RD_DATA} state_t;

    state_t         state;
    logic           last_wr;
    logic [I-1:0]   id_q;
    logic [L-1:0]   len_q;
    logic [1:0]     burst_q;
    logic [MAW-1:0] addr_q;
    logic [L-1:0]   beat_q;
    logic           err_q;

    logic           grant_wr;
    logic           grant_rd;
    logic [AXW-1:0] ax;
    logic [D-1:0]   wd_data;
    logic           wd_last;
    logic [M-1:0]   wd_strb;
    logic           reserved;
    logic           is_last;
    logic           wr_beat;
    logic           rd_issue;
    logic           err_now;
    logic [MAW-1:0] wrap_mask;
    logic [MAW-1:0] addr_inc;
    logic [MAW-1:0] addr_next;

    // Ties alternate: the side not served last wins, so a write wins the first tie.
    assign grant_wr = !awfifo_empty && (arfifo_empty || !last_wr);
    assign grant_rd = !arfifo_empty && !grant_wr;
    assign ax       = grant_wr ? awfifo_do : arfifo_do;

    assign wd_data  = wdfifo_do[D-1:0];
    assign wd_last  = wdfifo_do[D];
    assign wd_strb  = wdfifo_do[D+M:D+1];

    assign reserved = (burst_q == 2'b11);
    assign is_last  = (beat_q == len_q);
    assign wr_beat  = (state == WR) && !wdfifo_empty;
    assign rd_issue = (state == RD_ADDR) && !rdfifo_full;
    assign err_now  = err_q || reserved || (wd_last != is_last);

    // WRAP lengths are 2^n-1, so LEN itself is the mask of the wrapping low bits.
    assign wrap_mask = MAW'(len_q);
    assign addr_inc  = addr_q + 1'b1;

    always_comb begin
        addr_next = addr_q;
        case (burst_q)
            2'b01:   addr_next = addr_inc;
            2'b10:   addr_next = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
            default: addr_next = addr_q;
        endcase
    end

    assign wdfifo_pop  = wr_beat;
    assign mem_en      = (wr_beat || rd_issue) && !reserved;
    assign mem_we      = (wr_beat && !reserved) ? wd_strb : '0;
    assign mem_wdata   = (wr_beat && !reserved) ? wd_data : '0;
    assign mem_addr    = addr_q;
    assign bfifo_push  = (state == WRESP) && !bfifo_full;
    assign rdfifo_push = (state == RD_DATA);
    assign rdfifo_di   = rdfifo_push ? {id_q, is_last, reserved ? 2'b10 : 2'b00, reserved ? {D{1'b0}} : mem_rdata}
                                     : '0;
    assign busy        = (state != IDLE);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state      <= IDLE;
            last_wr    <= 1'b0;
            awfifo_pop <= 1'b0;
            arfifo_pop <= 1'b0;
            id_q       <= '0;
            len_q      <= '0;
            burst_q    <= '0;
            addr_q     <= '0;
            beat_q     <= '0;
            err_q      <= 1'b0;
            bfifo_di   <= '0;
        end else begin
            awfifo_pop <= 1'b0;
            arfifo_pop <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_wr || grant_rd) begin
                        awfifo_pop <= grant_wr;
                        arfifo_pop <= grant_rd;
                        id_q       <= ax[AXW-1 -: I];
                        len_q      <= ax[A+5 +: L];
                        burst_q    <= ax[A +: 2];
                        addr_q     <= ax[MAW+2:3];
                        beat_q     <= '0;
                        err_q      <= 1'b0;
                        state      <= grant_wr ? WR : RD_ADDR;
                    end
                end
                WR: begin
                    if (!wdfifo_empty) begin
                        addr_q <= addr_next;
                        beat_q <= beat_q + 1'b1;
                        err_q  <= err_now;
                        if (is_last) begin
                            bfifo_di <= {id_q, err_now ? 2'b10 : 2'b00};
                            state    <= WRESP;
                        end
                    end
                end
                WRESP: begin
                    if (!bfifo_full) begin
                        last_wr <= 1'b1;
                        state   <= IDLE;
                    end
                end
                RD_ADDR: begin
                    if (!rdfifo_full)
                        state <= RD_DATA;
                end
                RD_DATA: begin
                    addr_q <= addr_next;
                    beat_q <= beat_q + 1'b1;
                    if (is_last) begin
                        last_wr <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        state <= RD_ADDR;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{ax[A+4:A+2], ax[A-1:MAW+3], ax[2:0], wdfifo_do[D+M+I:D+M+1]};
endmodule

// File: tb/tb_axi_mem_ctrl.sv
// tb/tb_axi_mem_ctrl.sv - scoreboard bench for axi_mem_ctrl with FIFO, memory and burst reference models
module tb_axi_mem_ctrl;
    localparam int A = 32, I = 4, L = 4, D = 64, M = 8, MAW = 10;
    localparam int AXW = I + L + 3 + 2 + A;
    localparam int WDW = I + M + 1 + D;

    logic                 ACLK = 1'b0;
    logic                 ARESETn;
    logic                 awfifo_pop, wdfifo_pop, bfifo_push, arfifo_pop, rdfifo_push;
    logic [AXW-1:0]       awfifo_do = '0, arfifo_do = '0;
    logic                 awfifo_empty = 1'b1, wdfifo_empty = 1'b1, arfifo_empty = 1'b1;
    logic [WDW-1:0]       wdfifo_do = '0;
    logic [I+1:0]         bfifo_di;
    logic                 bfifo_full = 1'b0, rdfifo_full = 1'b0;
    logic [I+1+2+D-1:0]   rdfifo_di;
    logic                 mem_en, busy;
    logic [M-1:0]         mem_we;
    logic [MAW-1:0]       mem_addr;
    logic [D-1:0]         mem_wdata;
    logic [D-1:0]         mem_rdata = '0;

    always #5 ACLK = ~ACLK;

    axi_mem_ctrl dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .awfifo_pop(awfifo_pop), .awfifo_do(awfifo_do), .awfifo_empty(awfifo_empty),
        .wdfifo_pop(wdfifo_pop), .wdfifo_do(wdfifo_do), .wdfifo_empty(wdfifo_empty),
        .bfifo_push(bfifo_push), .bfifo_di(bfifo_di), .bfifo_full(bfifo_full),
        .arfifo_pop(arfifo_pop), .arfifo_do(arfifo_do), .arfifo_empty(arfifo_empty),
        .rdfifo_push(rdfifo_push), .rdfifo_di(rdfifo_di), .rdfifo_full(rdfifo_full),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    logic [AXW-1:0]       awq[$], arq[$];
    logic [WDW-1:0]       wq[$];
    logic [M+MAW+D-1:0]   exp_mem[$];
    logic [I+1:0]         exp_b[$];
    logic [I+1+2+D-1:0]   exp_r[$];
    logic [63:0]          dut_mem[1024];
    logic [63:0]          ref_mem[1024];
    int                   acc_cyc[$];
    int                   cyc = 0, n_mem = 0, tests = 0, errors = 0;
    bit                   gaps_on = 0, force_full = 0, wd_gap = 0, rd_gap = 0, b_gap = 0, last_wr_m = 0;
    logic [63:0]          tx_data[16];
    logic [7:0]           tx_strb[16];
    bit                   tx_last[16];

    bit                   s_aw, s_wd, s_ar, s_me;
    logic [M-1:0]         s_we;
    logic [MAW-1:0]       s_ad;
    logic [D-1:0]         s_wdat;

    always @(negedge ACLK) begin
        s_aw = awfifo_pop; s_wd = wdfifo_pop; s_ar = arfifo_pop; s_me = mem_en;
        s_we = mem_we; s_ad = mem_addr; s_wdat = mem_wdata;
    end

    // FIFO owners and memory: act on what was presented before the edge, then refresh the inputs.
    always @(posedge ACLK) begin
        cyc = cyc + 1;
        #1;
        if (ARESETn) begin
            if (s_aw && awq.size() > 0) void'(awq.pop_front());
            if (s_wd && wq.size() > 0)  void'(wq.pop_front());
            if (s_ar && arq.size() > 0) void'(arq.pop_front());
            if (s_me) begin
                if (s_we == '0) mem_rdata = dut_mem[s_ad];
                else for (int k = 0; k < M; k++) if (s_we[k]) dut_mem[s_ad][8*k +: 8] = s_wdat[8*k +: 8];
            end
        end
        s_aw = 0; s_wd = 0; s_ar = 0; s_me = 0;
        wd_gap = gaps_on && ($urandom_range(0, 3) == 0);
        rd_gap = gaps_on && ($urandom_range(0, 3) == 0);
        b_gap  = gaps_on && ($urandom_range(0, 2) == 0);
        #1;
        awfifo_empty = (awq.size() == 0);
        awfifo_do    = awfifo_empty ? '0 : awq[0];
        arfifo_empty = (arq.size() == 0);
        arfifo_do    = arfifo_empty ? '0 : arq[0];
        wdfifo_empty = (wq.size() == 0) || wd_gap;
        wdfifo_do    = (wq.size() == 0) ? '0 : wq[0];
        rdfifo_full  = force_full || rd_gap;
        bfifo_full   = b_gap;
    end

    always @(negedge ACLK) begin : monitor
        logic [M+MAW+D-1:0] m;
        logic [I+1:0]       b;
        logic [I+1+2+D-1:0] r;
        if (ARESETn) begin
            if (mem_en) begin
                n_mem++;
                acc_cyc.push_back(cyc);
                tests++;
                if (exp_mem.size() == 0) begin
                    errors++;
                    $display("FAIL mem_access: got we=%h addr=%0d wdata=%h, required no access", mem_we, mem_addr, mem_wdata);
                end else begin
                    m = exp_mem.pop_front();
                    if ({mem_we, mem_addr, mem_wdata} !== m) begin
                        errors++;
                        $display("FAIL mem_access: got we=%h addr=%0d wdata=%h, required we=%h addr=%0d wdata=%h",
                                 mem_we, mem_addr, mem_wdata, m[M+MAW+D-1 -: M], m[MAW+D-1 -: MAW], m[D-1:0]);
                    end
                end
            end
            if (rdfifo_full) begin
                tests++;
                if (mem_en && mem_we == '0) begin
                    errors++;
                    $display("FAIL read_while_full: got mem_en=1 addr=%0d, required mem_en=0", mem_addr);
                end
            end
            if (bfifo_push) begin
                tests++;
                if (exp_b.size() == 0) begin
                    errors++;
                    $display("FAIL bresp: got %h, required no push", bfifo_di);
                end else begin
                    b = exp_b.pop_front();
                    if (bfifo_di !== b) begin
                        errors++;
                        $display("FAIL bresp: got id=%h resp=%b, required id=%h resp=%b", bfifo_di[5:2], bfifo_di[1:0], b[5:2], b[1:0]);
                    end
                end
            end
            if (rdfifo_push) begin
                tests++;
                if (exp_r.size() == 0) begin
                    errors++;
                    $display("FAIL rdata: got %h, required no push", rdfifo_di);
                end else begin
                    r = exp_r.pop_front();
                    if (rdfifo_di !== r) begin
                        errors++;
                        $display("FAIL rdata: got id=%h last=%b resp=%b data=%h, required id=%h last=%b resp=%b data=%h",
                                 rdfifo_di[70:67], rdfifo_di[66], rdfifo_di[65:64], rdfifo_di[63:0],
                                 r[70:67], r[66], r[65:64], r[63:0]);
                    end
                end
            end
        end
    end

    function automatic int next_addr(input int a, input int burst, input int len);
        int sz = len + 1;
        case (burst)
            1:       return (a + 1) % 1024;
            2:       return (a / sz) * sz + ((a % sz) + 1) % sz;
            default: return a;
        endcase
    endfunction

    task automatic model_write(input logic [3:0] id, input int len, input int burst, input int word, input int stop);
        int a = word;
        bit err = (burst == 3);
        for (int bt = 0; bt <= len; bt++) begin
            if (tx_last[bt] != (bt == len)) err = 1;
            if (burst != 3 && (stop < 0 || bt <= stop)) begin
                exp_mem.push_back({tx_strb[bt], 10'(a), tx_data[bt]});
                if (stop < 0 || bt < stop)
                    for (int k = 0; k < 8; k++) if (tx_strb[bt][k]) ref_mem[a][8*k +: 8] = tx_data[bt][8*k +: 8];
            end
            a = next_addr(a, burst, len);
        end
        if (stop < 0) begin
            exp_b.push_back({id, err ? 2'b10 : 2'b00});
            last_wr_m = 1;
        end
    endtask

    task automatic model_read(input logic [3:0] id, input int len, input int burst, input int word);
        int a = word;
        for (int bt = 0; bt <= len; bt++) begin
            if (burst != 3) exp_mem.push_back({8'h00, 10'(a), 64'h0});
            exp_r.push_back({id, bt == len, burst == 3 ? 2'b10 : 2'b00, burst == 3 ? 64'h0 : ref_mem[a]});
            a = next_addr(a, burst, len);
        end
        last_wr_m = 0;
    endtask

    task automatic fill_wr(input int len, input bit bad);
        for (int bt = 0; bt < 16; bt++) begin
            tx_data[bt] = {$urandom, $urandom};
            tx_strb[bt] = 8'($urandom_range(1, 255));
            tx_last[bt] = (bt == len);
        end
        if (bad) begin
            int j = $urandom_range(0, len);
            tx_last[j] = !tx_last[j];
        end
    endtask

    task automatic push_aw(input logic [3:0] id, input int len, input int burst, input logic [31:0] addr);
        awq.push_back({id, 4'(len), 3'd3, 2'(burst), addr});
        for (int bt = 0; bt <= len; bt++) wq.push_back({id, tx_strb[bt], tx_last[bt], tx_data[bt]});
    endtask

    task automatic issue_write(input logic [3:0] id, input int len, input int burst, input logic [31:0] addr, input int stop);
        model_write(id, len, burst, int'(addr[12:3]), stop);
        push_aw(id, len, burst, addr);
    endtask

    task automatic issue_read(input logic [3:0] id, input int len, input int burst, input logic [31:0] addr);
        model_read(id, len, burst, int'(addr[12:3]));
        arq.push_back({id, 4'(len), 3'd3, 2'(burst), addr});
    endtask

    task automatic issue_pair(input logic [3:0] wid, input int wlen, input int wburst, input logic [31:0] waddr,
                              input logic [3:0] rid, input int rlen, input int rburst, input logic [31:0] raddr);
        if (!last_wr_m) begin
            model_write(wid, wlen, wburst, int'(waddr[12:3]), -1);
            model_read(rid, rlen, rburst, int'(raddr[12:3]));
        end else begin
            model_read(rid, rlen, rburst, int'(raddr[12:3]));
            model_write(wid, wlen, wburst, int'(waddr[12:3]), -1);
        end
        push_aw(wid, wlen, wburst, waddr);
        arq.push_back({rid, 4'(rlen), 3'd3, 2'(rburst), raddr});
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(posedge ACLK); #3;
            n++;
        end while ((busy || awq.size() > 0 || arq.size() > 0 || wq.size() > 0 ||
                    exp_mem.size() > 0 || exp_b.size() > 0 || exp_r.size() > 0) && n < 2000);
        tests++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL %s_timeout: got pending mem=%0d b=%0d r=%0d, required all drained",
                     name, exp_mem.size(), exp_b.size(), exp_r.size());
        end
    endtask

    task automatic check_outputs_zero(input string name);
        logic [255:0] o;
        o = 256'({awfifo_pop, wdfifo_pop, bfifo_push, bfifo_di, arfifo_pop, rdfifo_push, rdfifo_di,
                  mem_en, mem_we, mem_addr, mem_wdata, busy});
        tests++;
        if (o !== '0) begin
            errors++;
            $display("FAIL %s: got outputs %h, required all zero", name, o);
        end
    endtask

    task automatic rand_fields(output logic [3:0] id, output int len, output int burst, output logic [31:0] addr);
        id    = 4'($urandom);
        burst = $urandom_range(0, 3);
        len   = (burst == 2) ? (2 << $urandom_range(0, 3)) - 1 : $urandom_range(0, 15);
        addr  = $urandom;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  id, id2;
        logic [31:0] ad, ad2;
        int          ln, ln2, bu, bu2, base, n;

        ARESETn = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            dut_mem[i] = {32'(i) * 32'h9e3779b1, ~32'(i)};
            ref_mem[i] = {32'(i) * 32'h9e3779b1, ~32'(i)};
        end
        repeat (2) @(posedge ACLK);
        #3;
        check_outputs_zero("reset_state");

        // Both channels pending while reset is held: write first, then the read of the same words.
        fill_wr(3, 0);
        issue_pair(4'h1, 3, 1, 32'h0000_0100, 4'h2, 3, 1, 32'h0000_0100);
        repeat (2) @(posedge ACLK);
        #1 ARESETn = 1'b1;
        #1 check_outputs_zero("release_cycle");
        wait_done("tie1");

        fill_wr(1, 0);
        issue_pair(4'h3, 1, 1, 32'h0000_0200, 4'h4, 1, 1, 32'h0000_0100);
        wait_done("tie2");

        fill_wr(3, 0);
        for (int bt = 0; bt < 4; bt++) tx_strb[bt] = 8'hFF;
        acc_cyc.delete();
        issue_write(4'h5, 3, 1, 32'h0000_0040, -1);
        wait_done("incr_write");
        tests++;
        if (acc_cyc.size() != 4 || acc_cyc[acc_cyc.size()-1] - acc_cyc[0] != 3) begin
            errors++;
            $display("FAIL incr_write_spacing: got %0d accesses, required 4 on consecutive cycles", acc_cyc.size());
        end

        issue_read(4'h6, 3, 2, 32'h0000_0070);
        wait_done("wrap_read");

        fill_wr(1, 0);
        tx_last[0] = 1; tx_last[1] = 0;
        issue_write(4'h7, 1, 1, 32'h0000_0300, -1);
        wait_done("early_last");

        fill_wr(2, 0);
        issue_write(4'h8, 2, 3, 32'h0000_0400, -1);
        wait_done("reserved_write");
        issue_read(4'h9, 2, 3, 32'h0000_0400);
        wait_done("reserved_read");

        issue_read(4'hA, 7, 1, 32'h0000_0500);
        n = 0;
        do begin @(negedge ACLK); #1; n++; end while (exp_r.size() > 6 && n < 200);
        @(posedge ACLK);
        #1 force_full = 1;
        repeat (5) @(posedge ACLK);
        #1 force_full = 0;
        wait_done("full_stall");

        // Reset lands in the cycle that presents beat 2 of an 8-beat write.
        fill_wr(7, 0);
        base = n_mem;
        issue_write(4'hB, 7, 1, 32'h0000_0600, 2);
        n = 0;
        do begin @(negedge ACLK); #2; n++; end while (n_mem < base + 3 && n < 200);
        tests++;
        if (n_mem < base + 3) begin
            errors++;
            $display("FAIL abort_setup: got %0d writes, required 3", n_mem - base);
        end
        ARESETn = 1'b0;
        #1 check_outputs_zero("reset_mid_burst");
        awq.delete(); wq.delete(); arq.delete();
        last_wr_m = 0;
        repeat (3) @(posedge ACLK);
        #1 ARESETn = 1'b1;
        repeat (20) @(posedge ACLK);
        wait_done("after_abort");

        gaps_on = 1;
        for (int t = 0; t < 40; t++) begin
            @(posedge ACLK);
            #1;
            rand_fields(id, ln, bu, ad);
            case ($urandom_range(0, 3))
                0: begin
                    rand_fields(id2, ln2, bu2, ad2);
                    fill_wr(ln, $urandom_range(0, 4) == 0);
                    issue_pair(id, ln, bu, ad, id2, ln2, bu2, ad2);
                end
                1, 2: begin
                    fill_wr(ln, $urandom_range(0, 4) == 0);
                    issue_write(id, ln, bu, ad, -1);
                end
                default: issue_read(id, ln, bu, ad);
            endcase
            wait_done("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/axi_mem_ctrl.md
AXI_MEM_CTRL -- requirements
Module: axi_mem_ctrl

Interface
REQ-001 SHALL have parameters: A, 32, address width; I, 4, ID width; L, 4, burst-length width; D, 64, data width; M, D/8, strobe width; MAW, 10, memory word-address width.
REQ-002 SHALL have ports (name, direction, width, meaning):
- ACLK, in, 1, sole clock.
- ARESETn, in, 1, reset: asynchronous, active-low.
- awfifo_pop, out, 1, consume write-address entry.
- awfifo_do, in, I+L+3+2+A, {ID, LEN, SIZE, BURST, ADDR}.
- awfifo_empty, in, 1, write-address FIFO empty.
- wdfifo_pop, out, 1, consume write-data entry.
- wdfifo_do, in, I+M+1+D, {ID, STRB, LAST, DATA}.
- wdfifo_empty, in, 1, write-data FIFO empty.
- bfifo_push, out, 1, write-response strobe.
- bfifo_di, out, I+2, {ID, RESP}.
- bfifo_full, in, 1, write-response sink full.
- arfifo_pop, out, 1, consume read-address entry.
- arfifo_do, in, I+L+3+2+A, {ID, LEN, SIZE, BURST, ADDR}.
- arfifo_empty, in, 1, read-address FIFO empty.
- rdfifo_push, out, 1, read-data strobe.
- rdfifo_di, out, I+1+2+D, {ID, LAST, RESP, DATA}.
- rdfifo_full, in, 1, read-data FIFO full.
- mem_en, out, 1, memory access enable.
- mem_we, out, M, byte write enables (all 0 = read).
- mem_addr, out, MAW, word address.
- mem_wdata, out, D, write data.
- mem_rdata, in, D, read data, valid exactly 1 cycle after a read access.
- busy, out, 1, high in any state other than IDLE.

Function
REQ-003 SHALL treat FIFO *_do as valid whenever the matching *_empty is low; a pop consumes the entry at the next edge.
REQ-004 SHALL implement states IDLE, WR, WRESP, RD_ADDR, RD_DATA.
REQ-005 IDLE arbitration: only AW pending -> write; only AR pending -> read; both pending -> round-robin, the opposite of last_wr (last_wr resets to 0, so the first tie goes to write).
REQ-006 On grant, SHALL pulse awfifo_pop or arfifo_pop for 1 cycle; latch ID, LEN, BURST and word address ADDR[MAW+2:3]; clear the beat counter; go to WR or RD_ADDR.
REQ-007 In WR, each cycle with !wdfifo_empty: pulse wdfifo_pop; drive mem_en=1, mem_we=STRB, mem_wdata=DATA, mem_addr=current address. Rate is 1 beat/cycle.
REQ-008 In WR, if wdfifo_empty: mem_en=0 and mem_we=0; no state change.
REQ-009 Burst length SHALL be LEN+1 beats, counted by the controller; WLAST does not terminate the burst.
REQ-010 Address update per beat: BURST 2'b00 (FIXED) holds the address; 2'b01 (INCR) adds 1 modulo 2^MAW.
REQ-011 BURST 2'b10 (WRAP) SHALL increment within an aligned block of LEN+1 words: low log2(LEN+1) bits wrap, upper bits hold. LEN is restricted to 1, 3, 7 or 15.
REQ-012 BURST 2'b11 (reserved): no memory access (mem_we=0 for writes, no mem_en for reads); beats are still consumed or produced; RESP=2'b10 (SLVERR).
REQ-013 Write RESP SHALL be SLVERR if any beat's LAST bit is not exactly (beat==LEN), or if the burst is reserved; otherwise OKAY (2'b00).
REQ-014 After the final write beat, SHALL go to WRESP.
REQ-015 In WRESP, SHALL hold bfifo_di={latched ID, RESP} and pulse bfifo_push in the first cycle with !bfifo_full, then return to IDLE with last_wr=1.
REQ-016 RD_ADDR: if !rdfifo_full, drive mem_en=1, mem_we=0, mem_addr=current address, then go to RD_DATA; else wait with mem_en=0.
REQ-017 RD_DATA: pulse rdfifo_push with rdfifo_di={ID, beat==LEN, RESP, mem_rdata} (data 0 when reserved); advance address and counter.
REQ-018 After RD_DATA: last beat -> IDLE with last_wr=0; otherwise -> RD_ADDR. Throughput is 1 beat per 2 cycles.
REQ-019 This block SHALL be the sole producer into rdfifo, so a push in RD_DATA never overflows.
REQ-020 SHALL process one transaction at a time; no read/write overlap; no outstanding transactions.
REQ-021 Pop, push and mem strobes SHALL be 1-cycle pulses, never asserted in the same cycle as reset release.

Reset
REQ-022 ARESETn low SHALL asynchronously force: state IDLE, last_wr=0, all pops/pushes 0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, bfifo_di=0, rdfifo_di=0, busy=0.
REQ-023 Reset mid-burst SHALL abandon the transaction: no response and no further memory access; FIFO contents are the FIFO owner's concern.

Verification
REQ-024 INCR write, ADDR=0x40, LEN=3, STRB=0xFF, LAST on beat 3 -> mem_addr 8,9,10,11 on consecutive cycles; one bfifo_push {ID, 2'b00}.
REQ-025 AW and AR both pending from reset -> write served first, read next; second tie goes to write again.
REQ-026 WRAP read, ADDR=0x70 (word 14), LEN=3 -> mem_addr 14,15,12,13; RLAST only on the 4th push; RESP 00.
REQ-027 Write LEN=1 with LAST on beat 0 -> 2 memory writes; response SLVERR 2'b10.
REQ-028 rdfifo_full held for 5 cycles during a read burst -> no mem_en while full; all data delivered in order once full drops.
REQ-029 ARESETn low during beat 2 of an 8-beat write -> all outputs reset immediately; no bfifo_push after reset release.
